// File: rtl/thread_scheduler_if.sv
// Fetch/execute/halt signal bundle of the barrel-thread slot scheduler.
// The master modport is the surrounding core (or bench), slave is the scheduler.
interface thread_scheduler_if #(
  parameter int NUM_THREADS = 16
);
  localparam int IDX_W = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0] i_thread_enable;
  logic                   i_halt_req;
  logic [IDX_W-1:0]       i_halt_index;
  logic [NUM_THREADS-1:0] i_wake;
  logic                   o_init_busy;
  logic                   o_init_we;
  logic [IDX_W-1:0]       o_init_index;
  logic [IDX_W-1:0]       o_thread_index_counter;
  logic                   o_fetch_valid;
  logic [IDX_W-1:0]       o_thread_index_execute;
  logic                   o_execute_valid;
  logic [NUM_THREADS-1:0] o_halted_mask;
  logic                   o_all_idle;
  logic [31:0]            o_idle_slots;

  modport master (
    output i_thread_enable, i_halt_req, i_halt_index, i_wake,
    input  o_init_busy, o_init_we, o_init_index,
    input  o_thread_index_counter, o_fetch_valid,
    input  o_thread_index_execute, o_execute_valid,
    input  o_halted_mask, o_all_idle, o_idle_slots
  );

  modport slave (
    input  i_thread_enable, i_halt_req, i_halt_index, i_wake,
    output o_init_busy, o_init_we, o_init_index,
    output o_thread_index_counter, o_fetch_valid,
    output o_thread_index_execute, o_execute_valid,
    output o_halted_mask, o_all_idle, o_idle_slots
  );
endinterface

// File: rtl/thread_scheduler.sv
// Barrel-thread round-robin slot scheduler with PC-memory init sweep.
// Optional idle-slot counter built when SCHED_PERF_CNT_EN is defined.
module thread_scheduler #(
  parameter int NUM_THREADS = 16,
  parameter int PIPE_STAGES = 4
) (
  input logic clk,
  input logic reset,
  thread_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_THREADS);

  if (NUM_THREADS < 2 || (NUM_THREADS & (NUM_THREADS - 1)) != 0) begin : g_bad_threads
    $error("NUM_THREADS must be a power of two and at least 2");
  end
  if (PIPE_STAGES < 1) begin : g_bad_stages
    $error("PIPE_STAGES must be at least 1");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       sweep, sweep_next;
  logic [IDX_W-1:0]       slot, slot_next;
  logic [NUM_THREADS-1:0] halted, halted_next;
  logic [NUM_THREADS-1:0] halt_set;
  logic                   init_busy, init_we;
  logic                   fetch_valid;
  logic [IDX_W-1:0]       pipe_idx [PIPE_STAGES];
  logic                   pipe_vld [PIPE_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INIT;
      sweep  <= '0;
      slot   <= '0;
      halted <= '0;
    end else begin
      state  <= state_next;
      sweep  <= sweep_next;
      slot   <= slot_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    state_next = state;
    sweep_next = sweep;
    slot_next  = slot;
    init_busy  = 1'b0;
    init_we    = 1'b0;
    unique case (state)
      INIT: begin
        init_busy  = 1'b1;
        init_we    = 1'b1;
        sweep_next = sweep + IDX_W'(1);
        if (sweep == IDX_W'(NUM_THREADS - 1))
          state_next = RUN;
      end
      RUN: begin
        slot_next = slot + IDX_W'(1);
      end
      default: state_next = INIT;
    endcase
  end

  // Wake is applied last so a same-edge halt cannot swallow it
  always_comb begin
    halt_set = '0;
    if (bus.i_halt_req)
      halt_set = NUM_THREADS'(1) << bus.i_halt_index;
    halted_next = (halted | halt_set) & ~bus.i_wake;
  end

  assign fetch_valid = (state == RUN) &
                       bus.i_thread_enable[slot] &
                       ~halted[slot];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        pipe_idx[k] <= '0;
        pipe_vld[k] <= 1'b0;
      end
    end else begin
      pipe_idx[0] <= slot;
      pipe_vld[0] <= fetch_valid;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        pipe_idx[k] <= pipe_idx[k-1];
        pipe_vld[k] <= pipe_vld[k-1];
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      idle_cnt <= '0;
    else if (state == RUN && !fetch_valid)
      idle_cnt <= idle_cnt + 32'd1;
  end

  assign bus.o_idle_slots = idle_cnt;
`else
  assign bus.o_idle_slots = '0;
`endif

  // The sweep counter wraps to 0 on leaving INIT, so the index rests at 0
  assign bus.o_init_busy            = init_busy;
  assign bus.o_init_we              = init_we;
  assign bus.o_init_index           = sweep;
  assign bus.o_thread_index_counter = slot;
  assign bus.o_fetch_valid          = fetch_valid;
  assign bus.o_thread_index_execute = pipe_idx[PIPE_STAGES-1];
  assign bus.o_execute_valid        = pipe_vld[PIPE_STAGES-1];
  assign bus.o_halted_mask          = halted;
  assign bus.o_all_idle             = ~|(bus.i_thread_enable & ~halted);
endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Barrel-thread slot scheduler for the multithreaded RISC-V core.
- After reset, it sequences initialisation of the per-thread PC memory with the startup address.
- It then issues thread indices to fetch in strict round-robin order, one slot per cycle, and marks each slot valid or bubble from the per-thread enable and halt state.
- It delays the issued index through a fixed pipeline so the execute stage sees the thread that owns its instruction, and the PC write-back targets that thread.

Parameters:
- NUM_THREADS, 16, number of hardware threads; power of two, minimum 2.
- PIPE_STAGES, 4, cycles from fetch-slot issue to execute stage; minimum 1.
- IDX_W, $clog2(NUM_THREADS), thread index width (derived; do not override).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- i_thread_enable  in  NUM_THREADS  per-thread run enable; bit t=1 allows thread t to issue
- i_halt_req  in  1  execute stage requests a halt of i_halt_index (e.g. WFI/EBREAK)
- i_halt_index  in  IDX_W  thread to halt
- i_wake  in  NUM_THREADS  per-thread wake pulses; each clears that thread's halted bit
- o_init_busy  out  1  PC-memory initialisation sweep in progress
- o_init_we  out  1  PC-memory write enable during the sweep
- o_init_index  out  IDX_W  PC-memory address being initialised
- o_thread_index_counter  out  IDX_W  thread owning the current fetch slot
- o_fetch_valid  out  1  current fetch slot carries a real instruction (0 = bubble)
- o_thread_index_execute  out  IDX_W  thread owning the execute-stage slot
- o_execute_valid  out  1  execute-stage slot is real
- o_halted_mask  out  NUM_THREADS  current halted bits
- o_all_idle  out  1  no thread is both enabled and not halted
- o_idle_slots  out  32  count of bubble slots in RUN (see Optional Feature)

Behaviour:
- Reset (synchronous, sampled at clk edge while reset=1) forces:
  - state=INIT, sweep counter=0, slot counter=0, halted mask=0, all pipeline valid bits=0.
  - o_init_busy=1, o_init_we=1, o_init_index=0.
  - o_thread_index_counter=0, o_fetch_valid=0, o_thread_index_execute=0, o_execute_valid=0, o_idle_slots=0.
- Reset asserted in any state, mid-sweep or mid-run, aborts and restarts from the reset state above.
- INIT state:
  - o_init_we=1; o_init_index steps 0,1,…,NUM_THREADS-1, one per cycle.
  - o_fetch_valid=0 throughout.
  - In the cycle after index NUM_THREADS-1, state=RUN, o_init_busy=0, o_init_we=0, o_init_index holds 0.
  - Total INIT duration after reset release: exactly NUM_THREADS cycles.
- RUN state:
  - The slot counter increments by 1 every cycle, wrapping NUM_THREADS-1 → 0. Slots are never skipped, so each thread has exactly NUM_THREADS cycles between slots; this keeps the barrel pipeline hazard-free.
  - o_fetch_valid = i_thread_enable[cnt] & ~halted[cnt], evaluated combinationally from the current counter.
- Halt and wake:
  - On a clk edge with i_halt_req=1, halted[i_halt_index] is set.
  - On a clk edge with i_wake[t]=1, halted[t] is cleared.
  - Same-edge halt and wake on the same thread: wake wins, so no wakeup is lost.
  - Halt and wake are accepted in INIT too; the halted mask is not cleared by the end of INIT.
  - A thread halted at edge E produces a bubble if its slot is on or after the cycle following E.
- Execute delay line:
  - A shift register of {index, valid} pairs, PIPE_STAGES deep. o_thread_index_execute and o_execute_valid equal the fetch values from exactly PIPE_STAGES cycles earlier.
  - Reset clears all valid bits.
  - Slots issued during INIT propagate with valid=0.
- Enable changes:
  - i_thread_enable is sampled only at slot issue.
  - Clearing an enable bit does not squash that thread's slots already in the pipeline.
- o_all_idle = ~|(i_thread_enable & ~halted), combinational.
- Width rules: the slot counter and sweep counter are IDX_W bits and wrap naturally. NUM_THREADS being a power of two is required; the implementation checks it with an elaboration-time assertion.

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- When defined:
  - o_idle_slots is a 32-bit counter, cleared by reset.
  - It increments on every RUN-state cycle with o_fetch_valid=0, wraps at 2^32, and does not count during INIT.
- When undefined: o_idle_slots is tied to 0 and no counter logic is built. The port list is identical in both builds.

Test Plan:
- INIT sweep:
  - Stimulus: assert reset for 3 cycles, then release, all enables=1.
  - Required: o_init_we=1 with o_init_index 0..15 over 16 cycles, then o_init_busy=0. o_fetch_valid=1 on the first RUN cycle with o_thread_index_counter=0.
- Round robin and delay:
  - Stimulus: RUN with all enabled.
  - Required: o_thread_index_counter reads 0..15,0 and wraps from 15 to 0. o_thread_index_execute equals the counter value from 4 cycles earlier, with o_execute_valid=1.
- Enable mask:
  - Stimulus: i_thread_enable=16'h00F0.
  - Required: o_fetch_valid=1 only for slots 4–7. o_all_idle=0. With the Optional Feature enabled, o_idle_slots increases by 12 per 16-cycle round.
- Halt and wake:
  - Stimulus: i_halt_req=1 with i_halt_index=5 for one cycle.
  - Required: halted[5]=1 and the next slot 5 is a bubble. A pulse on i_wake[5] clears halted[5] and the following slot 5 is valid.
  - Stimulus: halt and wake of thread 9 on the same edge.
  - Required: halted[9] stays 0.
- Reset mid-run:
  - Stimulus: assert reset while the counter is 11 and the pipeline is full.
  - Required: o_execute_valid=0 at the next edge, the halted mask clears, INIT restarts at index 0, and o_idle_slots=0.
